// File: rtl/mod_mult_add_arbiter.sv
// Round-robin front end sharing one pipelined residue multiply-add unit between NUM_REQ requesters.
// Optional operand range check: define RANGE_CHECK_EN.
module mod_mult_add_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned MODULUS    = 177147,
    parameter int unsigned PIPE_LAT   = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opa,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opb,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [DATA_WIDTH-1:0]           mma_op_a,
    output logic [DATA_WIDTH-1:0]           mma_op_b,
    input  logic [DATA_WIDTH-1:0]           mma_result,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_err,
    output logic [$clog2(PIPE_LAT+2)-1:0]   in_flight,
    output logic                            busy
);

    localparam int unsigned IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNTW = $clog2(PIPE_LAT + 2);

    typedef struct packed {
        logic           vld;
        logic           err;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0]        ptr;
    tag_t [PIPE_LAT:0]     tag_pipe;
    tag_t                  new_tag;
    tag_t                  last_tag;
    logic                  grant_any;
    logic [IDW-1:0]        grant_id;
    int unsigned           scan_idx;
    logic                  xfer;
    logic                  op_err;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(ptr) + k) % NUM_REQ;
            if (!grant_any && req_valid[scan_idx[IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any && reset_n) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign xfer  = grant_any & reset_n;
    assign sel_a = req_opa[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_b = req_opb[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
`ifdef RANGE_CHECK_EN
        op_err = (32'(sel_a) >= MODULUS) || (32'(sel_b) >= MODULUS);
`else
        op_err = 1'b0;
`endif
        new_tag     = '0;
        new_tag.vld = xfer;
        new_tag.err = xfer & op_err;
        new_tag.id  = xfer ? grant_id : '0;
    end

    assign last_tag = tag_pipe[PIPE_LAT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            tag_pipe  <= '0;
            mma_op_a  <= '0;
            mma_op_b  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            in_flight <= '0;
        end else begin
            if (xfer) begin
                ptr <= (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + IDW'(1);
            end
            // Rejected or idle slots drive zeros so the datapath never sees stale operands.
            mma_op_a <= (xfer && !op_err) ? sel_a : '0;
            mma_op_b <= (xfer && !op_err) ? sel_b : '0;
            tag_pipe <= {tag_pipe[PIPE_LAT-1:0], new_tag};

            rsp_valid <= '0;
            if (last_tag.vld) begin
                rsp_valid[last_tag.id] <= 1'b1;
                rsp_data               <= last_tag.err ? '0 : mma_result;
            end

            case ({xfer, last_tag.vld})
                2'b10:   in_flight <= in_flight + CNTW'(1);
                2'b01:   in_flight <= in_flight - CNTW'(1);
                default: ;
            endcase
        end
    end

`ifdef RANGE_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= last_tag.vld & last_tag.err;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    assign busy = (in_flight != '0);

endmodule

// File: tb/tb_mod_mult_add_arbiter.sv
// Self-checking bench for mod_mult_add_arbiter: directed scenarios plus random traffic
// against a queue-based transaction model and a behavioural datapath stand-in.
module tb_mod_mult_add_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned DW  = 18;
    localparam int unsigned MOD = 177147;
    localparam int unsigned LAT = 8;
    localparam int unsigned CW  = $clog2(LAT + 2);

    typedef struct {
        int unsigned   due;
        int unsigned   id;
        logic [DW-1:0] data;
        bit            err;
    } rsp_t;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_opa   = '0;
    logic [NR*DW-1:0] req_opb   = '0;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    mma_op_a;
    logic [DW-1:0]    mma_op_b;
    logic [DW-1:0]    mma_result;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             rsp_err;
    logic [CW-1:0]    in_flight;
    logic             busy;

    always #5 clk = ~clk;

    mod_mult_add_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MODULUS   (MOD),
        .PIPE_LAT  (LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_opa   (req_opa),
        .req_opb   (req_opb),
        .req_ready (req_ready),
        .mma_op_a  (mma_op_a),
        .mma_op_b  (mma_op_b),
        .mma_result(mma_result),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .in_flight (in_flight),
        .busy      (busy)
    );

    // Opaque datapath stand-in: result for operands presented in cycle k appears in cycle k+LAT.
    function automatic logic [DW-1:0] dp_func(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint unsigned t;
        t = (64'(a) * 64'd7 + 64'(b)) % 64'(MOD);
        return DW'(t) ^ 18'h15a5a;
    endfunction

    logic [DW-1:0] dp_pipe [LAT];
    always @(posedge clk) begin
        dp_pipe[0] <= dp_func(mma_op_a, mma_op_b);
        for (int unsigned i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign mma_result = dp_pipe[LAT-1];

    function automatic bit op_bad(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef RANGE_CHECK_EN
        return (32'(a) >= MOD) || (32'(b) >= MOD);
`else
        return 1'b0;
`endif
    endfunction

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    int unsigned   cyc      = 0;
    int unsigned   m_ptr    = 0;
    int            g_last   = -1;
    rsp_t          exp_q[$];
    logic [DW-1:0] exp_a    = '0;
    logic [DW-1:0] exp_b    = '0;
    int unsigned   acc_cyc  = 0;
    int unsigned   rsp_seen = 0;
    int unsigned   last_rsp_cyc = 0;
    logic [NR-1:0] last_rsp_vec = '0;
    logic [DW-1:0] last_rsp_data = '0;
    logic          last_rsp_err = 1'b0;
    logic [NR-1:0] obs_ready = '0;
    logic [DW-1:0] obs_op_b = '0;
    int unsigned   max_flight = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check all outputs at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        int          g;
        int unsigned idx;
        rsp_t        e;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        bit          bad;
        @(negedge clk);
        obs_ready = req_ready;
        obs_op_b  = mma_op_b;
        if (rsp_valid != '0) begin
            rsp_seen++;
            last_rsp_cyc  = cyc;
            last_rsp_vec  = rsp_valid;
            last_rsp_data = rsp_data;
            last_rsp_err  = rsp_err;
        end
        if (32'(in_flight) > max_flight) max_flight = 32'(in_flight);
        if (!reset_n) begin
            exp_q.delete();
            m_ptr  = 0;
            exp_a  = '0;
            exp_b  = '0;
            g_last = -1;
            check_eq("rst_ready", 32'(req_ready), 32'd0);
            check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
            check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
            check_eq("rst_in_flight", 32'(in_flight), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_op_a", 32'(mma_op_a), 32'd0);
            check_eq("rst_op_b", 32'(mma_op_b), 32'd0);
        end else begin
            g = -1;
            for (int unsigned k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (g < 0 && req_valid[idx]) g = int'(idx);
            end
            check_eq("ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            check_eq("op_a", 32'(mma_op_a), 32'(exp_a));
            check_eq("op_b", 32'(mma_op_b), 32'(exp_b));
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check_eq("rsp_valid", 32'(rsp_valid), 32'd1 << e.id);
                check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
                check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
            end else begin
                check_eq("rsp_idle", 32'(rsp_valid), 32'd0);
                check_eq("rsp_err_idle", 32'(rsp_err), 32'd0);
            end
            check_eq("in_flight", 32'(in_flight), exp_q.size());
            check_eq("busy", 32'(busy), 32'(exp_q.size() != 0));
            check_eq("in_flight_cap", 32'(32'(in_flight) <= LAT + 1), 32'd1);
            if (g >= 0) begin
                a   = req_opa[g*DW +: DW];
                b   = req_opb[g*DW +: DW];
                bad = op_bad(a, b);
                exp_q.push_back('{due: cyc + LAT + 2, id: g, data: bad ? '0 : dp_func(a, b), err: bad});
                exp_a   = bad ? '0 : a;
                exp_b   = bad ? '0 : b;
                m_ptr   = (int'(g) + 1) % NR;
                acc_cyc = cyc;
            end else begin
                exp_a = '0;
                exp_b = '0;
            end
            g_last = g;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_req(input int unsigned i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_valid[i]        = 1'b1;
        req_opa[i*DW +: DW] = a;
        req_opb[i*DW +: DW] = b;
    endtask

    function automatic logic [DW-1:0] rand_op();
        if ($urandom_range(7, 0) == 0) return DW'($urandom_range(32'h3ffff, MOD));
        return DW'($urandom_range(MOD - 1, 0));
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks", n_checks);
        $fatal(1);
    end

    initial begin
        int unsigned   dut_gcount [NR];
        int unsigned   base;
        logic [DW-1:0] sa;
        logic [DW-1:0] sb;

        // Reset held with every requester asserting valid.
        for (int unsigned i = 0; i < NR; i++) set_req(i, DW'($urandom_range(MOD - 1, 0)), DW'($urandom_range(MOD - 1, 0)));
        #1 reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        // Continuous contention for 16 clocks: strict rotation starting at requester 0.
        for (int unsigned i = 0; i < NR; i++) dut_gcount[i] = 0;
        max_flight = 0;
        for (int unsigned n = 0; n < 16; n++) begin
            tick();
            if (n == 0) check_eq("first_grant", 32'(obs_ready), 32'd1);
            check_eq("fair_seq", 32'(obs_ready), 32'd1 << (n % NR));
            for (int unsigned i = 0; i < NR; i++) if (obs_ready[i]) dut_gcount[i]++;
            if (g_last >= 0) set_req(32'(g_last), rand_op(), rand_op());
        end
        for (int unsigned i = 0; i < NR; i++) check_eq("fair_count", dut_gcount[i], 32'd4);
        check_eq("full_occupancy", max_flight, LAT + 1);
        req_valid = '0;
        repeat (LAT + 4) tick();

        // Single operation from requester 1.
        set_req(1, 18'h1d387, 18'h12345);
        base = rsp_seen;
        tick();
        check_eq("single_grant", 32'(obs_ready), 32'b0010);
        req_valid = '0;
        repeat (LAT + 4) tick();
        check_eq("single_rsp_count", rsp_seen - base, 32'd1);
        check_eq("single_latency", last_rsp_cyc - acc_cyc, LAT + 2);
        check_eq("single_rsp_vec", 32'(last_rsp_vec), 32'b0010);
        check_eq("single_rsp_data", 32'(last_rsp_data), 32'(dp_func(18'h1d387, 18'h12345)));

        // Out-of-range addend.
        set_req(2, 18'd5, 18'd177147);
        tick();
        req_valid = '0;
        tick();
`ifdef RANGE_CHECK_EN
        check_eq("range_op_b", 32'(obs_op_b), 32'd0);
`else
        check_eq("range_op_b", 32'(obs_op_b), 32'd177147);
`endif
        repeat (LAT + 3) tick();
`ifdef RANGE_CHECK_EN
        check_eq("range_err", 32'(last_rsp_err), 32'd1);
        check_eq("range_data", 32'(last_rsp_data), 32'd0);
`else
        check_eq("range_err", 32'(last_rsp_err), 32'd0);
        check_eq("range_data", 32'(last_rsp_data), 32'(dp_func(18'd5, 18'd177147)));
`endif

        // Reset while three operations are in flight: none of them may respond.
        for (int unsigned i = 0; i < 3; i++) set_req(i, rand_op(), rand_op());
        repeat (3) begin
            tick();
            if (g_last >= 0) req_valid[g_last] = 1'b0;
        end
        tick();
        check_eq("pre_reset_in_flight", 32'(in_flight), 32'd3);
        reset_n = 1'b0;
        base    = rsp_seen;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (LAT + 6) tick();
        check_eq("flushed_rsp_count", rsp_seen - base, 32'd0);
        sa = DW'($urandom_range(MOD - 1, 0));
        sb = DW'($urandom_range(MOD - 1, 0));
        set_req(3, sa, sb);
        tick();
        req_valid = '0;
        repeat (LAT + 4) tick();
        check_eq("fresh_rsp_count", rsp_seen - base, 32'd1);
        check_eq("fresh_rsp_vec", 32'(last_rsp_vec), 32'b1000);
        check_eq("fresh_rsp_data", 32'(last_rsp_data), 32'(dp_func(sa, sb)));

        // Random traffic; requesters hold until granted.
        repeat (400) begin
            tick();
            if (g_last >= 0) begin
                if ($urandom_range(3, 0) != 0) set_req(32'(g_last), rand_op(), rand_op());
                else req_valid[g_last] = 1'b0;
            end
            for (int unsigned i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(2, 0) == 0) set_req(i, rand_op(), rand_op());
            end
        end
        req_valid = '0;
        repeat (LAT + 4) tick();
        check_eq("drained_in_flight", 32'(in_flight), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
